// File: rtl/lrc_pkg.sv
// Shared definitions for the left/right consistency sequencer.
package lrc_pkg;

  localparam int unsigned DEF_IMG_W    = 640;
  localparam int unsigned DEF_IMG_H    = 480;
  localparam int unsigned DEF_MAX_DISP = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_RUN,
    ST_TAIL,
    ST_GAP
  } lrc_state_t;

  // Counter width helper that never yields a zero-width vector.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/lrc_sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the oldest entry.
module lrc_sync_fifo
  import lrc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = clog2_min1(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards contents by realigning the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write, no reset needed on the array itself.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/lrc_seq_ctrl.sv
// Sequencer feeding the LRC datapath: left eye leads by MAX_DISP columns,
// then left/right pairs, then the right-eye tail, then a fixed inter-line gap.
module lrc_seq_ctrl
  import lrc_pkg::*;
#(
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H,
  parameter int unsigned MAX_DISP   = DEF_MAX_DISP,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GAP_CYC    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] disp_l,
  input  logic       disp_l_valid,
  output logic       disp_l_ready,
  input  logic [7:0] disp_r,
  input  logic       disp_r_valid,
  output logic       disp_r_ready,
  output logic [7:0] lrc_l,
  output logic [7:0] lrc_r,
  output logic       lrc_en,
  output logic       lrc_r_valid,
  output logic       busy,
  output logic       line_done,
  output logic       frame_done,
  output logic       err_ovf,
  input  logic       clr_err
);

  localparam int unsigned COL_W = clog2_min1(IMG_W + MAX_DISP);
  localparam int unsigned ROW_W = clog2_min1(IMG_H);
  localparam int unsigned GAP_W = clog2_min1(GAP_CYC);

  localparam logic [COL_W-1:0] LEAD_LAST = COL_W'(MAX_DISP - 1);
  localparam logic [COL_W-1:0] RUN_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] TAIL_LAST = COL_W'(IMG_W + MAX_DISP - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

  lrc_state_t       state, state_nxt;
  logic [COL_W-1:0] col_cnt, col_nxt;
  logic [ROW_W-1:0] row_cnt, row_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;

  logic       l_full, l_empty, r_full, r_empty;
  logic [7:0] l_dout, r_dout;
  logic       pop_l, pop_r, issue, line_end, frame_end;

  assign disp_l_ready = !l_full;
  assign disp_r_ready = !r_full;
  assign busy         = (state != ST_IDLE);

  lrc_sync_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo_l (
    .clk   (clk),
    .rst   (rst),
    .push  (disp_l_valid),
    .din   (disp_l),
    .pop   (pop_l),
    .dout  (l_dout),
    .full  (l_full),
    .empty (l_empty)
  );

  lrc_sync_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo_r (
    .clk   (clk),
    .rst   (rst),
    .push  (disp_r_valid),
    .din   (disp_r),
    .pop   (pop_r),
    .dout  (r_dout),
    .full  (r_full),
    .empty (r_empty)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // Issue decision, pops and next-state; phase changes ride on the last issue.
  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    gap_nxt   = gap_cnt;
    pop_l     = 1'b0;
    pop_r     = 1'b0;
    issue     = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !l_empty) state_nxt = ST_LEAD;
      end
      ST_LEAD: begin
        if (!l_empty) begin
          issue   = 1'b1;
          pop_l   = 1'b1;
          col_nxt = col_cnt + 1'b1;
          if (col_cnt == LEAD_LAST) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!l_empty && !r_empty) begin
          issue   = 1'b1;
          pop_l   = 1'b1;
          pop_r   = 1'b1;
          col_nxt = col_cnt + 1'b1;
          if (col_cnt == RUN_LAST) state_nxt = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (!r_empty) begin
          issue = 1'b1;
          pop_r = 1'b1;
          if (col_cnt == TAIL_LAST) begin
            state_nxt = ST_GAP;
            col_nxt   = '0;
            gap_nxt   = '0;
            line_end  = 1'b1;
            frame_end = (row_cnt == ROW_LAST);
          end else begin
            col_nxt = col_cnt + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (row_cnt == ROW_LAST) begin
            row_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            row_nxt   = row_cnt + 1'b1;
            state_nxt = (enable && !l_empty) ? ST_LEAD : ST_IDLE;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered datapath outputs; pixel buses hold their value across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      lrc_l       <= '0;
      lrc_r       <= '0;
      lrc_en      <= 1'b0;
      lrc_r_valid <= 1'b0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      lrc_en      <= issue;
      lrc_r_valid <= pop_r;
      line_done   <= line_end;
      frame_done  <= frame_end;
      if (issue) begin
        lrc_l <= pop_l ? l_dout : '0;
        lrc_r <= pop_r ? r_dout : '0;
      end
    end
  end

  // Sticky overflow flag; a new overflow outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
    end else if ((disp_l_valid && !disp_l_ready) || (disp_r_valid && !disp_r_ready)) begin
      err_ovf <= 1'b1;
    end else if (clr_err) begin
      err_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lrc_seq_ctrl.sv
// Randomized bench for lrc_seq_ctrl with a queue-based line model.
module tb_lrc_seq_ctrl;

  localparam int unsigned IMG_W       = 8;
  localparam int unsigned IMG_H       = 2;
  localparam int unsigned MAX_DISP    = 4;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned GAP_CYC     = 2;
  localparam int          LINE_ISSUES = IMG_W + MAX_DISP;
  localparam int          BIG         = 1 << 30;

  logic       clk = 1'b0;
  logic       rst, enable, clr_err;
  logic [7:0] disp_l, disp_r;
  logic       disp_l_valid, disp_r_valid;
  logic       disp_l_ready, disp_r_ready;
  logic [7:0] lrc_l, lrc_r;
  logic       lrc_en, lrc_r_valid, busy, line_done, frame_done, err_ovf;

  always #5 clk = ~clk;

  lrc_seq_ctrl #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .MAX_DISP   (MAX_DISP),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .disp_l       (disp_l),
    .disp_l_valid (disp_l_valid),
    .disp_l_ready (disp_l_ready),
    .disp_r       (disp_r),
    .disp_r_valid (disp_r_valid),
    .disp_r_ready (disp_r_ready),
    .lrc_l        (lrc_l),
    .lrc_r        (lrc_r),
    .lrc_en       (lrc_en),
    .lrc_r_valid  (lrc_r_valid),
    .busy         (busy),
    .line_done    (line_done),
    .frame_done   (frame_done),
    .err_ovf      (err_ovf),
    .clr_err      (clr_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: accepted pixels per eye, position within line, row, event counts.
  logic [7:0] ql[$];
  logic [7:0] qr[$];
  int m_idx = 0, m_row = 0, m_lines = 0, m_frames = 0;
  int gap_left = 0, pf_cnt = 0;
  logic [7:0] prev_l = '0, prev_r = '0;

  // Stimulus control: 0 idle, 1 random streams, 2 left valid held high.
  int drv_mode = 0;
  int l_sent = 0, r_sent = 0, l_quota = 0, r_quota = 0, r_cap = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive after the edge, then sample and update the model mid-cycle.
  task automatic tick();
    logic [7:0] el, er;
    int         erv;
    @(posedge clk);
    #1;
    disp_l_valid = 1'b0;
    disp_r_valid = 1'b0;
    if (drv_mode == 1) begin
      if (l_sent < l_quota && disp_l_ready && $urandom_range(0, 3) != 0) begin
        disp_l_valid = 1'b1;
        disp_l       = 8'($urandom);
        l_sent++;
      end
      if (r_sent < r_quota && r_sent < r_cap && disp_r_ready && $urandom_range(0, 3) != 0) begin
        disp_r_valid = 1'b1;
        disp_r       = 8'($urandom);
        r_sent++;
      end
    end else if (drv_mode == 2) begin
      disp_l_valid = 1'b1;
      disp_l       = 8'($urandom);
    end
    @(negedge clk);
    if (rst) begin
      ql.delete();
      qr.delete();
      m_idx    = 0;
      m_row    = 0;
      gap_left = 0;
      pf_cnt   = 0;
      prev_l   = '0;
      prev_r   = '0;
    end else begin
      if (disp_l_valid && disp_l_ready) ql.push_back(disp_l);
      if (disp_r_valid && disp_r_ready) qr.push_back(disp_r);
      if (gap_left > 0) begin
        chk("gap_quiet", lrc_en, 0);
        gap_left--;
      end
      if (pf_cnt > 0) begin
        pf_cnt++;
        if (pf_cnt == 2) chk("gap_busy", busy, 1);
        else if (pf_cnt == 3) begin
          chk("frame_idle", busy, 0);
          pf_cnt = 0;
        end
      end
      if (lrc_en) begin
        el  = '0;
        er  = '0;
        erv = 0;
        if (m_idx < IMG_W) begin
          chk("l_avail", int'(ql.size() > 0), 1);
          if (ql.size() > 0) el = ql.pop_front();
        end
        if (m_idx >= MAX_DISP) begin
          chk("r_avail", int'(qr.size() > 0), 1);
          if (qr.size() > 0) er = qr.pop_front();
          erv = 1;
        end
        chk("lrc_l", lrc_l, el);
        chk("lrc_r", lrc_r, er);
        chk("lrc_r_valid", lrc_r_valid, erv);
        chk("busy_issue", busy, 1);
        m_idx++;
        if (m_idx == LINE_ISSUES) begin
          chk("line_done", line_done, 1);
          chk("frame_done", frame_done, int'(m_row == IMG_H - 1));
          if (m_row == IMG_H - 1) begin
            m_row = 0;
            m_frames++;
            pf_cnt = 1;
          end else begin
            m_row++;
          end
          m_lines++;
          m_idx    = 0;
          gap_left = GAP_CYC;
        end else begin
          chk("line_done_early", line_done, 0);
          chk("frame_done_early", frame_done, 0);
        end
      end else begin
        chk("stall_r_valid", lrc_r_valid, 0);
        chk("stall_line_done", line_done, 0);
        chk("stall_frame_done", frame_done, 0);
        chk("hold_l", lrc_l, prev_l);
        chk("hold_r", lrc_r, prev_r);
        if (m_idx > 0) chk("busy_stall", busy, 1);
      end
      prev_l = lrc_l;
      prev_r = lrc_r;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_lrc_en"}, lrc_en, 0);
    chk({tag, "_lrc_l"}, lrc_l, 0);
    chk({tag, "_lrc_r"}, lrc_r, 0);
    chk({tag, "_r_valid"}, lrc_r_valid, 0);
    chk({tag, "_line_done"}, line_done, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_ovf"}, err_ovf, 0);
  endtask

  task automatic do_reset();
    drv_mode = 0;
    enable   = 1'b0;
    clr_err  = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();
    chk("reset_l_ready", disp_l_ready, 1);
    chk("reset_r_ready", disp_r_ready, 1);
  endtask

  task automatic run_until_lines(input int target, input int budget, input string tag);
    int n = 0;
    while (m_lines < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, m_lines, target);
  endtask

  task automatic run_until_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (m_frames < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, m_frames, target);
  endtask

  task automatic run_until_idx(input int target, input int budget, input string tag);
    int n = 0;
    while (m_idx != target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, m_idx, target);
  endtask

  task automatic add_lines(input int n);
    l_quota = l_sent + n * IMG_W;
    r_quota = r_sent + n * IMG_W;
  endtask

  initial begin
    int en_cnt;
    rst          = 1'b1;
    enable       = 1'b0;
    clr_err      = 1'b0;
    disp_l       = '0;
    disp_r       = '0;
    disp_l_valid = 1'b0;
    disp_r_valid = 1'b0;
    do_reset();

    // Two back-to-back lines forming one frame.
    enable   = 1'b1;
    drv_mode = 1;
    r_cap    = BIG;
    add_lines(2);
    run_until_frames(m_frames + 1, 800, "frame_a_timeout");
    repeat (3) tick();
    chk("frame_a_idle", busy, 0);
    chk("frame_a_ql_empty", ql.size(), 0);
    chk("frame_a_qr_empty", qr.size(), 0);

    // Several random frames.
    add_lines(6);
    run_until_frames(m_frames + 3, 3000, "random_timeout");

    // Right stream starved right after the first RUN issue.
    do_reset();
    enable   = 1'b1;
    drv_mode = 1;
    add_lines(1);
    r_cap = r_sent + 1;
    run_until_idx(MAX_DISP + 1, 300, "starve_reach");
    en_cnt = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      en_cnt += int'(lrc_en);
    end
    chk("starve_no_issue", en_cnt, 0);
    chk("starve_busy", busy, 1);
    r_cap = BIG;
    run_until_lines(m_lines + 1, 400, "starve_resume");
    add_lines(1);
    run_until_frames(m_frames + 1, 400, "starve_frame");

    // Enable dropped mid-line: line finishes, then the FSM parks in IDLE.
    add_lines(2);
    run_until_idx(MAX_DISP + 1, 300, "endrop_reach");
    enable = 1'b0;
    run_until_lines(m_lines + 1, 400, "endrop_line");
    tick();
    tick();
    chk("endrop_idle", busy, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk("endrop_stay_idle", busy, 0);
    end
    enable = 1'b1;
    run_until_frames(m_frames + 1, 400, "endrop_row1_frame");

    // Reset in the middle of row 1 drops the line; next frame starts at row 0.
    add_lines(2);
    run_until_lines(m_lines + 1, 400, "midrst_row0");
    run_until_idx(6, 300, "midrst_reach");
    drv_mode = 0;
    rst      = 1'b1;
    tick();
    check_outputs_zero("midrst");
    rst = 1'b0;
    tick();
    chk("midrst_l_ready", disp_l_ready, 1);
    chk("midrst_r_ready", disp_r_ready, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("midrst_fifo_flushed", busy, 0);
    end
    drv_mode = 1;
    add_lines(2);
    run_until_frames(m_frames + 1, 800, "midrst_frame");
    chk("midrst_ql_empty", ql.size(), 0);
    chk("midrst_qr_empty", qr.size(), 0);

    // Left FIFO overflow and sticky error handling.
    do_reset();
    enable   = 1'b0;
    drv_mode = 2;
    for (int unsigned j = 1; j <= 20; j++) begin
      tick();
      if (j <= 16) chk("ovf_err_clear", err_ovf, 0);
      if (j == 16) chk("ovf_ready_15", disp_l_ready, 1);
      if (j == 17) begin
        chk("ovf_ready_16", disp_l_ready, 0);
        chk("ovf_err_16", err_ovf, 0);
      end
      if (j == 18) begin
        chk("ovf_err_17", err_ovf, 1);
        drv_mode = 0;
        clr_err  = 1'b1;
      end
      if (j == 19) chk("ovf_set_wins", err_ovf, 1);
      if (j == 20) begin
        chk("ovf_cleared", err_ovf, 0);
        chk("ovf_r_ready", disp_r_ready, 1);
        clr_err = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
